// File: rtl/complex_divider.sv
// Iterative complex divider (a+bi)/(c+di), signed Q(I).(F); define CDIV_ROUND_EN for round-half-away-from-zero quotients.
// Latency 2*(I+F)+F+3 cycles from accepted i_start to o_valid; one op in flight, i_start ignored while o_busy.
module complex_divider #(
  parameter int I = 4,
  parameter int F = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic signed [I+F-1:0] i_data1_re,
  input  logic signed [I+F-1:0] i_data1_im,
  input  logic signed [I+F-1:0] i_data2_re,
  input  logic signed [I+F-1:0] i_data2_im,
  output logic                o_busy,
  output logic                o_valid,
  output logic signed [I+F-1:0] o_data_re,
  output logic signed [I+F-1:0] o_data_im,
  output logic                o_div0,
  output logic                o_sat
);
  localparam int W  = I + F;
  localparam int DW = 2 * W + F;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] L_POS = {{(DW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic [DW-1:0] L_NEG = {{(DW-W){1'b0}}, 1'b1, {(W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_SUM, S_DIV, S_SAT} state_t;
  state_t r_state, w_next;

  logic signed [W-1:0]   r_a, r_b, r_c, r_d;
  logic signed [2*W-1:0] r_ac, r_bd, r_bc, r_ad;
  logic [2*W-1:0]        r_den;
  logic                  r_neg_re, r_neg_im;
  logic [DW-1:0]         r_dvd_re, r_dvd_im, r_quo_re, r_quo_im;
  logic [2*W-1:0]        r_rem_re, r_rem_im;
  logic [CW-1:0]         r_cnt;

  logic signed [2*W-1:0] w_a, w_b, w_c, w_d, w_cc, w_dd;
  logic signed [2*W:0]   w_nre, w_nim;
  logic [2*W-1:0]        w_mag_re, w_mag_im, w_den;
  logic [DW-1:0]         w_rnd, w_dvd_re, w_dvd_im;
  logic [2*W:0]          w_trial_re, w_trial_im, w_dsor;
  logic [2*W-1:0]        w_diff_re, w_diff_im;
  logic                  w_ge_re, w_ge_im, w_div0;
  logic [W:0]            w_res_re, w_res_im;

  // Returns {saturated, value}: applies sign to the magnitude quotient and clamps to W bits.
  function automatic logic [W:0] f_sat(input logic [DW-1:0] q, input logic neg);
    logic [W:0] r;
    if (neg) begin
      if (q > L_NEG) r = {1'b1, 1'b1, {(W-1){1'b0}}};
      else           r = {1'b0, -q[W-1:0]};
    end else if (q > L_POS) begin
      r = {1'b1, 1'b0, {(W-1){1'b1}}};
    end else begin
      r = {1'b0, q[W-1:0]};
    end
    return r;
  endfunction

  assign o_busy = (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_MUL;
      S_MUL:   w_next = S_SUM;
      S_SUM:   w_next = S_DIV;
      S_DIV:   if (r_cnt == '0) w_next = S_SAT;
      S_SAT:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_a   = (2*W)'(r_a);
  assign w_b   = (2*W)'(r_b);
  assign w_c   = (2*W)'(r_c);
  assign w_d   = (2*W)'(r_d);
  assign w_cc  = w_c * w_c;
  assign w_dd  = w_d * w_d;
  // |c|^2+|d|^2 <= 2^(2W-1), so the unsigned 2W-bit sum never overflows.
  assign w_den = $unsigned(w_cc) + $unsigned(w_dd);
  assign w_nre = (2*W+1)'(r_ac) + (2*W+1)'(r_bd);
  assign w_nim = (2*W+1)'(r_bc) - (2*W+1)'(r_ad);
  assign w_mag_re = w_nre[2*W] ? (2*W)'(-w_nre) : w_nre[2*W-1:0];
  assign w_mag_im = w_nim[2*W] ? (2*W)'(-w_nim) : w_nim[2*W-1:0];
`ifdef CDIV_ROUND_EN
  assign w_rnd = DW'(w_den >> 1);
`else
  assign w_rnd = '0;
`endif
  assign w_dvd_re = {w_mag_re, {F{1'b0}}} + w_rnd;
  assign w_dvd_im = {w_mag_im, {F{1'b0}}} + w_rnd;

  // Restoring step: remainder stays below den, so the difference always fits 2W bits.
  assign w_dsor     = {1'b0, r_den};
  assign w_trial_re = {r_rem_re, r_dvd_re[DW-1]};
  assign w_trial_im = {r_rem_im, r_dvd_im[DW-1]};
  assign w_ge_re    = (w_trial_re >= w_dsor);
  assign w_ge_im    = (w_trial_im >= w_dsor);
  assign w_diff_re  = w_trial_re[2*W-1:0] - r_den;
  assign w_diff_im  = w_trial_im[2*W-1:0] - r_den;

  assign w_div0   = (r_den == '0);
  assign w_res_re = f_sat(r_quo_re, r_neg_re);
  assign w_res_im = f_sat(r_quo_im, r_neg_im);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_c <= '0; r_d <= '0;
      r_ac <= '0; r_bd <= '0; r_bc <= '0; r_ad <= '0;
      r_den <= '0; r_neg_re <= 1'b0; r_neg_im <= 1'b0;
      r_dvd_re <= '0; r_dvd_im <= '0; r_quo_re <= '0; r_quo_im <= '0;
      r_rem_re <= '0; r_rem_im <= '0; r_cnt <= '0;
      o_valid <= 1'b0; o_data_re <= '0; o_data_im <= '0; o_div0 <= 1'b0; o_sat <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_a <= i_data1_re; r_b <= i_data1_im;
          r_c <= i_data2_re; r_d <= i_data2_im;
        end
        S_MUL: begin
          r_ac <= w_a * w_c; r_bd <= w_b * w_d;
          r_bc <= w_b * w_c; r_ad <= w_a * w_d;
        end
        S_SUM: begin
          r_den    <= w_den;
          r_neg_re <= w_nre[2*W];
          r_neg_im <= w_nim[2*W];
          r_dvd_re <= w_dvd_re; r_dvd_im <= w_dvd_im;
          r_rem_re <= '0; r_rem_im <= '0;
          r_quo_re <= '0; r_quo_im <= '0;
          r_cnt    <= CW'(DW - 1);
        end
        S_DIV: begin
          r_dvd_re <= r_dvd_re << 1;
          r_dvd_im <= r_dvd_im << 1;
          r_rem_re <= w_ge_re ? w_diff_re : w_trial_re[2*W-1:0];
          r_rem_im <= w_ge_im ? w_diff_im : w_trial_im[2*W-1:0];
          r_quo_re <= {r_quo_re[DW-2:0], w_ge_re};
          r_quo_im <= {r_quo_im[DW-2:0], w_ge_im};
          r_cnt    <= r_cnt - 1'b1;
        end
        S_SAT: begin
          o_data_re <= w_div0 ? '0 : w_res_re[W-1:0];
          o_data_im <= w_div0 ? '0 : w_res_im[W-1:0];
          o_div0    <= w_div0;
          o_sat     <= !w_div0 && (w_res_re[W] || w_res_im[W]);
          o_valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_complex_divider.sv
// Bench for complex_divider at I=4, F=12: directed corner cases plus random operands against an arithmetic model.
module tb_complex_divider;
  localparam int W   = 16;
  localparam int F   = 12;
  localparam int LAT = 2 * W + F + 3;

  logic                clk = 1'b0;
  logic                rst, i_start;
  logic signed [W-1:0] a, b, c, d;
  logic                o_busy, o_valid, o_div0, o_sat;
  logic signed [W-1:0] o_data_re, o_data_im;

  int vectors = 0;
  int errors  = 0;

  typedef struct { logic [W-1:0] re, im; logic div0, sat; } res_t;
  typedef struct { logic [W-1:0] a, b, c, d, re, im; logic sat; } vec_t;

  complex_divider #(.I(4), .F(12)) dut (
    .clk(clk), .rst(rst), .i_start(i_start),
    .i_data1_re(a), .i_data1_im(b), .i_data2_re(c), .i_data2_im(d),
    .o_busy(o_busy), .o_valid(o_valid),
    .o_data_re(o_data_re), .o_data_im(o_data_im),
    .o_div0(o_div0), .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  // One quotient component: {saturated, value}.
  function automatic logic [W:0] comp(input longint n, input longint den);
    longint mag, q, v, lim;
    logic s;
    mag = (n < 0) ? -n : n;
    q = mag * 4096;
`ifdef CDIV_ROUND_EN
    q = q + den / 2;
`endif
    q = q / den;
    lim = 32768;
    s = 1'b0;
    if (n < 0) begin
      if (q > lim) begin q = lim; s = 1'b1; end
      v = -q;
    end else begin
      if (q > lim - 1) begin q = lim - 1; s = 1'b1; end
      v = q;
    end
    return {s, v[W-1:0]};
  endfunction

  function automatic res_t model(input logic signed [W-1:0] ma, mb, mc, md);
    res_t r;
    longint la, lb, lc, ld, den;
    logic [W:0] cr, ci;
    la = ma; lb = mb; lc = mc; ld = md;
    den = lc * lc + ld * ld;
    if (den == 0) begin
      r.re = '0; r.im = '0; r.div0 = 1'b1; r.sat = 1'b0;
    end else begin
      cr = comp(la * lc + lb * ld, den);
      ci = comp(lb * lc - la * ld, den);
      r.re = cr[W-1:0]; r.im = ci[W-1:0];
      r.div0 = 1'b0; r.sat = cr[W] | ci[W];
    end
    return r;
  endfunction

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (o_valid) begin lat = n; break; end
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, ib, ic, id, output int lat);
    i_start = 1'b1; a = ia; b = ib; c = ic; d = id;
    @(posedge clk); #1;
    i_start = 1'b0;
    a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
    wait_valid(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1; i_start = 1'b0; a = '0; b = '0; c = '0; d = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({o_busy, o_valid, o_data_re, o_data_im, o_div0, o_sat} !== '0) begin
      errors++;
      $display("FAIL reset busy=%b valid=%b re=%h im=%h div0=%b sat=%b, all must be 0",
               o_busy, o_valid, o_data_re, o_data_im, o_div0, o_sat);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tab[5];
    int lat;
    tab[0] = '{16'h1000, 16'h1000, 16'h1000, 16'h0000, 16'h1000, 16'h1000, 1'b0};
    tab[1] = '{16'h1000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'hF000, 1'b0};
`ifdef CDIV_ROUND_EN
    tab[2] = '{16'h2000, 16'h0000, 16'h3000, 16'h0000, 16'h0AAB, 16'h0000, 1'b0};
`else
    tab[2] = '{16'h2000, 16'h0000, 16'h3000, 16'h0000, 16'h0AAA, 16'h0000, 1'b0};
`endif
    tab[3] = '{16'h7000, 16'h0000, 16'h0100, 16'h0000, 16'h7FFF, 16'h0000, 1'b1};
    tab[4] = '{16'h9000, 16'h0000, 16'h0100, 16'h0000, 16'h8000, 16'h0000, 1'b1};
    for (int i = 0; i < 5; i++) begin
      issue(tab[i].a, tab[i].b, tab[i].c, tab[i].d, lat);
      vectors++;
      if (lat != LAT) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, LAT);
      end
      vectors++;
      if ({o_data_re, o_data_im, o_div0, o_sat} !== {tab[i].re, tab[i].im, 1'b0, tab[i].sat}) begin
        errors++;
        $display("FAIL directed_result[%0d] got re=%h im=%h div0=%b sat=%b want re=%h im=%h div0=0 sat=%b",
                 i, o_data_re, o_data_im, o_div0, o_sat, tab[i].re, tab[i].im, tab[i].sat);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, rc, rd;
    res_t e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      case (i % 4)
        0, 1: begin rc = W'($urandom); rd = W'($urandom); end
        2: begin rc = W'($urandom_range(0, 1023)) - 16'd512; rd = W'($urandom_range(0, 255)) - 16'd128; end
        default: begin rc = W'($urandom_range(0, 8191)) - 16'd4096; rd = '0; end
      endcase
      e = model(ra, rb, rc, rd);
      issue(ra, rb, rc, rd, lat);
      vectors++;
      if (lat != LAT || {o_data_re, o_data_im, o_div0, o_sat} !== {e.re, e.im, e.div0, e.sat}) begin
        errors++;
        $display("FAIL random[%0d] (%h+%hi)/(%h+%hi) got lat=%0d re=%h im=%h div0=%b sat=%b want lat=%0d re=%h im=%h div0=%b sat=%b",
                 i, ra, rb, rc, rd, lat, o_data_re, o_data_im, o_div0, o_sat, LAT, e.re, e.im, e.div0, e.sat);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    int lat;
    issue(16'h3456, 16'hC123, 16'h0000, 16'h0000, lat);
    vectors++;
    if (lat != LAT || {o_data_re, o_data_im, o_div0, o_sat, o_busy} !== {32'h0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL div0 got lat=%0d re=%h im=%h div0=%b sat=%b busy=%b want lat=%0d re=0 im=0 div0=1 sat=0 busy=0",
               lat, o_data_re, o_data_im, o_div0, o_sat, o_busy, LAT);
    end
    i_start = 1'b1; a = 16'h1234; b = 16'hF800; c = 16'h0C00; d = 16'h0400;
    e = model(a, b, c, d);
    @(posedge clk); #1;
    i_start = 1'b0;
    vectors++;
    if ({o_busy, o_valid} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_accept got busy=%b valid=%b want busy=1 valid=0", o_busy, o_valid);
    end
    wait_valid(lat);
    vectors++;
    if (lat != LAT || {o_data_re, o_data_im, o_div0, o_sat} !== {e.re, e.im, e.div0, e.sat}) begin
      errors++;
      $display("FAIL b2b_result got lat=%0d re=%h im=%h div0=%b sat=%b want lat=%0d re=%h im=%h div0=%b sat=%b",
               lat, o_data_re, o_data_im, o_div0, o_sat, LAT, e.re, e.im, e.div0, e.sat);
    end
  endtask

  task automatic test_busy_ignore();
    res_t e;
    logic [2*W-1:0] prev;
    int lat;
    prev = {o_data_re, o_data_im};
    i_start = 1'b1; a = 16'h1800; b = 16'h0800; c = 16'h1000; d = 16'h0400;
    e = model(a, b, c, d);
    @(posedge clk); #1;
    for (int i = 1; i <= 10; i++) begin
      i_start = 1'b1; a = W'($urandom); b = W'($urandom); c = W'($urandom); d = W'($urandom);
      @(posedge clk); #1;
      if (i == 5) begin
        vectors++;
        if ({o_data_re, o_data_im} !== prev || o_busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_hold got re=%h im=%h busy=%b want re/im=%h busy=1", o_data_re, o_data_im, o_busy, prev);
        end
      end
    end
    i_start = 1'b0;
    wait_valid(lat);
    if (lat > 0) lat = lat + 10;
    vectors++;
    if (lat != LAT || {o_data_re, o_data_im, o_div0, o_sat} !== {e.re, e.im, e.div0, e.sat}) begin
      errors++;
      $display("FAIL busy_ignore got lat=%0d re=%h im=%h div0=%b sat=%b want lat=%0d re=%h im=%h div0=%b sat=%b",
               lat, o_data_re, o_data_im, o_div0, o_sat, LAT, e.re, e.im, e.div0, e.sat);
    end
    @(posedge clk); #1;
    vectors++;
    if ({o_busy, o_valid} !== 2'b00) begin
      errors++;
      $display("FAIL busy_no_queue got busy=%b valid=%b want 0 0", o_busy, o_valid);
    end
  endtask

  task automatic test_abort();
    res_t e;
    int lat;
    logic seen;
    i_start = 1'b1; a = 16'h2000; b = 16'h1000; c = 16'h0800; d = 16'h0000;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++;
    if ({o_busy, o_valid, o_data_re, o_data_im, o_div0, o_sat} !== '0) begin
      errors++;
      $display("FAIL abort_state busy=%b valid=%b re=%h im=%h div0=%b sat=%b, all must be 0",
               o_busy, o_valid, o_data_re, o_data_im, o_div0, o_sat);
    end
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(posedge clk); #1;
      if (o_valid || o_busy) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet got activity=%b want 0", seen);
    end
    e = model(16'hE000, 16'h0400, 16'h0000, 16'hF000);
    issue(16'hE000, 16'h0400, 16'h0000, 16'hF000, lat);
    vectors++;
    if (lat != LAT || {o_data_re, o_data_im, o_div0, o_sat} !== {e.re, e.im, e.div0, e.sat}) begin
      errors++;
      $display("FAIL abort_recover got lat=%0d re=%h im=%h div0=%b sat=%b want lat=%0d re=%h im=%h div0=%b sat=%b",
               lat, o_data_re, o_data_im, o_div0, o_sat, LAT, e.re, e.im, e.div0, e.sat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_busy_ignore();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
